// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the 5-stage pipeline hazard controller.
//               Defines the stage count, the index of each pipe register in the
//               stall/flush vectors, the controller state type and a helper
//               that builds one-hot stage masks.
// Revision    : 1.0 - initial release
//==============================================================================
package pipe_ctrl_pkg;

    localparam int NUM_STAGES = 4;

    // Bit positions in the stall/flush vectors
    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } ctrl_state_t;

    // One-hot mask selecting a single pipe register
    function automatic logic [NUM_STAGES-1:0] stage_bit(input int stg);
        return {{(NUM_STAGES-1){1'b0}}, 1'b1} << stg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
`default_nettype none
//==============================================================================
// Module      : pipe_hazard_detect
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in ID reads a register that the load in EX is
//               about to write. x0 is never a hazard.
// Ports       : i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2
//               i_ex_valid, i_ex_is_load, i_ex_rd
//               o_load_use - hazard present this cycle
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_live;

    assign w_rs1_hit   = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit   = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    // Writes to x0 are discarded, so a load targeting x0 never blocks
    assign w_load_live = i_ex_valid && i_ex_is_load && (i_ex_rd != '0);
    assign o_load_use  = i_id_valid && w_load_live && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl
// Description : Hazard/sequencing controller for a 5-stage RV32I pipeline.
//               Produces per-pipe-register stall/flush, PC hold and PC
//               redirect. Handles load-use bubbles, taken-branch squash with
//               a configurable kill window, and imem/dmem wait stalls.
//               Priority: sync_rst > dmem_busy > taken branch > SQUASH
//               kill / load-use > imem_busy.
// Ports       : clk, sync_rst (synchronous, active-high)
//               id_* / ex_*     - hazard and branch inputs from ID and EX
//               imem_busy, dmem_busy - memory wait inputs
//               stall[3:0], flush[3:0] - [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB
//               pc_hold, pc_redirect, redirect_pc
// Option      : PIPE_CTRL_STATS_EN adds saturating counters bubble_cnt,
//               redirect_cnt and memwait_cnt (32 bit each).
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_W         = 5,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic                  ex_br_taken,
    input  logic [XLEN-1:0]       ex_br_target,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  pc_hold,
    output logic                  pc_redirect,
    output logic [XLEN-1:0]       redirect_pc
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           redirect_cnt,
    output logic [31:0]           memwait_cnt
`endif
);

    localparam logic [NUM_STAGES-1:0] c_MASK_ALL  = '1;
    // Back end frozen behind MEM, MEM/WB emits a bubble
    localparam logic [NUM_STAGES-1:0] c_STALL_MEM = stage_bit(STG_IFID) | stage_bit(STG_IDEX)
                                                  | stage_bit(STG_EXMEM);
    localparam logic [NUM_STAGES-1:0] c_FLUSH_MEM = stage_bit(STG_MEMWB);
    // Kill the two younger instructions fetched down the wrong path
    localparam logic [NUM_STAGES-1:0] c_FLUSH_BR  = stage_bit(STG_IFID) | stage_bit(STG_IDEX);
    // Hold the consumer in ID, inject a bubble into EX
    localparam logic [NUM_STAGES-1:0] c_STALL_LU  = stage_bit(STG_IFID);
    localparam logic [NUM_STAGES-1:0] c_FLUSH_LU  = stage_bit(STG_IDEX);
    localparam logic [NUM_STAGES-1:0] c_FLUSH_IF  = stage_bit(STG_IFID);
    localparam logic [3:0]            c_SQ_RELOAD = (SQUASH_CYCLES > 0) ? 4'(SQUASH_CYCLES - 1) : 4'd0;

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_load_use;
    logic        w_br;

    pipe_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_rs1 (id_use_rs1),
        .i_id_use_rs2 (id_use_rs2),
        .i_ex_valid   (ex_valid),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .o_load_use   (w_load_use)
    );

    assign w_br = ex_valid && ex_br_taken;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        stall       = '0;
        flush       = '0;
        pc_hold     = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (sync_rst) begin
            flush   = c_MASK_ALL;
            pc_hold = 1'b1;
        end else if (dmem_busy) begin
            // Whole controller frozen; a pending branch is re-seen next cycle
            stall   = c_STALL_MEM;
            flush   = c_FLUSH_MEM;
            pc_hold = 1'b1;
        end else if (w_br) begin
            pc_redirect = 1'b1;
            redirect_pc = ex_br_target;
            flush       = c_FLUSH_BR;
            w_cnt_nxt   = c_SQ_RELOAD;
            w_state_nxt = (SQUASH_CYCLES == 0) ? RUN : SQUASH;
        end else if (r_state == SQUASH) begin
            // Fetch keeps going but whatever lands in IF/ID is stale
            flush = c_FLUSH_IF;
            if (r_cnt == 4'd0) begin
                w_state_nxt = RUN;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
        end else if (w_load_use) begin
            stall   = c_STALL_LU;
            flush   = c_FLUSH_LU;
            pc_hold = 1'b1;
        end else if (imem_busy) begin
            flush   = c_FLUSH_IF;
            pc_hold = 1'b1;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    // A stall pattern of exactly IF/ID only arises from a load-use bubble
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            bubble_cnt   <= 32'd0;
            redirect_cnt <= 32'd0;
            memwait_cnt  <= 32'd0;
        end else begin
            if ((stall == c_STALL_LU) && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
            if (pc_redirect && (redirect_cnt != 32'hFFFF_FFFF))
                redirect_cnt <= redirect_cnt + 32'd1;
            if (dmem_busy && (memwait_cnt != 32'hFFFF_FFFF))
                memwait_cnt <= memwait_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (SQUASH_CYCLES = 2).
//               Each scenario queues per-cycle stimulus with its expected
//               outputs, then replays the queue against the controller.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_ctrl;

    localparam int c_XLEN = 32;
    localparam int c_REG_W = 5;
    localparam int c_SQ = 2;
    localparam logic [31:0] c_T1 = 32'h0000_0100;
    localparam logic [31:0] c_T2 = 32'h0000_0A40;

    typedef struct {
        logic        rst;
        logic        id_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic        ex_valid;
        logic        is_load;
        logic [4:0]  rd;
        logic        br;
        logic [31:0] tgt;
        logic        imem;
        logic        dmem;
    } stim_t;

    // {stall[3:0], flush[3:0], pc_hold, pc_redirect, redirect_pc[31:0]}
    typedef logic [41:0] exp_t;

    logic              clk = 1'b0;
    logic              sync_rst;
    logic              id_valid;
    logic [c_REG_W-1:0] id_rs1;
    logic [c_REG_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_valid;
    logic              ex_is_load;
    logic [c_REG_W-1:0] ex_rd;
    logic              ex_br_taken;
    logic [c_XLEN-1:0] ex_br_target;
    logic              imem_busy;
    logic              dmem_busy;
    logic [3:0]        stall;
    logic [3:0]        flush;
    logic              pc_hold;
    logic              pc_redirect;
    logic [c_XLEN-1:0] redirect_pc;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0]       bubble_cnt;
    logic [31:0]       redirect_cnt;
    logic [31:0]       memwait_cnt;
`endif

    int    n_checks = 0;
    int    n_pass   = 0;
    stim_t stq[$];
    exp_t  sbq[$];

    always #5 clk = ~clk;

    pipe_ctrl #(
        .XLEN          (c_XLEN),
        .REG_W         (c_REG_W),
        .SQUASH_CYCLES (c_SQ)
    ) dut (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_br_taken  (ex_br_taken),
        .ex_br_target (ex_br_target),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .stall        (stall),
        .flush        (flush),
        .pc_hold      (pc_hold),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .redirect_cnt (redirect_cnt),
        .memwait_cnt  (memwait_cnt)
`endif
    );

    // ---------------- stimulus / expectation builders ----------------
    function automatic exp_t ex(input logic [3:0] st, input logic [3:0] fl,
                                input logic h, input logic r, input logic [31:0] pc);
        return {st, fl, h, r, pc};
    endfunction

    function automatic stim_t s_idle();
        stim_t s;
        s.rst = 1'b0; s.id_valid = 1'b0; s.rs1 = '0; s.rs2 = '0;
        s.use1 = 1'b0; s.use2 = 1'b0; s.ex_valid = 1'b0; s.is_load = 1'b0;
        s.rd = '0; s.br = 1'b0; s.tgt = '0; s.imem = 1'b0; s.dmem = 1'b0;
        return s;
    endfunction

    function automatic stim_t s_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic use1,
                                   input logic [4:0] rs2, input logic use2);
        stim_t s;
        s = s_idle();
        s.id_valid = 1'b1; s.ex_valid = 1'b1; s.is_load = 1'b1; s.rd = rd;
        s.rs1 = rs1; s.use1 = use1; s.rs2 = rs2; s.use2 = use2;
        return s;
    endfunction

    function automatic stim_t s_br(input logic [31:0] t);
        stim_t s;
        s = s_idle();
        s.ex_valid = 1'b1; s.br = 1'b1; s.tgt = t;
        return s;
    endfunction

    function automatic string show(input exp_t v);
        return $sformatf("stall=%b flush=%b hold=%b redir=%b pc=%h",
                         v[41:38], v[37:34], v[33], v[32], v[31:0]);
    endfunction

    task automatic drive(input stim_t s);
        sync_rst = s.rst; id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_use_rs1 = s.use1; id_use_rs2 = s.use2; ex_valid = s.ex_valid;
        ex_is_load = s.is_load; ex_rd = s.rd; ex_br_taken = s.br;
        ex_br_target = s.tgt; imem_busy = s.imem; dmem_busy = s.dmem;
    endtask

    task automatic push(input stim_t s, input exp_t e);
        stq.push_back(s);
        sbq.push_back(e);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t s;
        exp_t got, want;
        int k = 0;
        s = s_br(c_T1); s.rst = 1'b1;                        // reset beats a branch
        push(s, ex(4'b0000, 4'b1111, 1'b1, 1'b0, 32'h0));
        s = s_idle(); s.rst = 1'b1; s.dmem = 1'b1;           // and beats dmem_busy
        push(s, ex(4'b0000, 4'b1111, 1'b1, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL reset[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t got, want;
        int k = 0;
        push(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), ex(4'b0001, 4'b0010, 1'b1, 1'b0, 32'h0));
        push(s_idle(),                           ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        push(s_lu(5'd9, 5'd3, 1'b1, 5'd9, 1'b1), ex(4'b0001, 4'b0010, 1'b1, 1'b0, 32'h0));
        push(s_lu(5'd9, 5'd3, 1'b1, 5'd9, 1'b0), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        push(s_lu(5'd5, 5'd5, 1'b0, 5'd1, 1'b1), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        // x0 exemption
        push(s_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL load_use[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s;
        exp_t got, want;
        int k = 0;
        s = s_idle(); s.imem = 1'b1;
        push(s, ex(4'b0000, 4'b0001, 1'b1, 1'b0, 32'h0));
        s = s_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); s.imem = 1'b1;   // load-use outranks imem
        push(s, ex(4'b0001, 4'b0010, 1'b1, 1'b0, 32'h0));
        s = s_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); s.dmem = 1'b1;   // dmem outranks load-use
        push(s, ex(4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0));
        s = s_br(c_T1); s.ex_valid = 1'b0;                       // unqualified branch ignored
        push(s, ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL mem_wait[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        exp_t got, want;
        int k = 0;
        push(s_br(c_T1), ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T1));
        push(s_idle(),   ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        // load-use pattern during the kill window is ignored
        push(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL redirect[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dmem_squash();
        stim_t s;
        exp_t got, want;
        int k = 0;
        s = s_idle(); s.dmem = 1'b1;
        push(s_br(c_T1), ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T1));
        push(s_idle(),   ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++) push(s, ex(4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL dmem_squash[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_combo();
        stim_t s;
        exp_t got, want;
        int k = 0;
        // branch + load-use: branch wins
        s = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); s.br = 1'b1; s.tgt = c_T1;
        push(s, ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T1));
        push(s_idle(), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        // branch + imem_busy: redirect, PC not held
        s = s_br(c_T2); s.imem = 1'b1;
        push(s, ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T2));
        push(s_idle(), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        // branch + dmem_busy: redirect deferred
        s = s_br(c_T1); s.dmem = 1'b1;
        push(s, ex(4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0));
        push(s_br(c_T1), ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T1));
        push(s_idle(), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(), ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL branch_combo[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, want;
        int k = 0;
        push(s_br(c_T1), ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T1));
        push(s_br(c_T2), ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T2));  // reloads the window
        push(s_idle(),   ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL back_to_back[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_squash();
        stim_t s;
        exp_t got, want;
        int k = 0;
        s = s_idle(); s.rst = 1'b1;
        push(s_br(c_T1), ex(4'b0000, 4'b0011, 1'b0, 1'b1, c_T1));
        push(s,          ex(4'b0000, 4'b1111, 1'b1, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        push(s_idle(),   ex(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0));
        while (stq.size() != 0) begin
            drive(stq.pop_front());
            want = sbq.pop_front();
            @(negedge clk);
            got = {stall, flush, pc_hold, pc_redirect, redirect_pc};
            n_checks++;
            if (got !== want) $display("FAIL reset_mid_squash[%0d]: got %s, required %s", k, show(got), show(want));
            else n_pass++;
`ifdef PIPE_CTRL_STATS_EN
            if (k == 2) begin
                n_checks++;
                if ({bubble_cnt, redirect_cnt, memwait_cnt} !== 96'd0)
                    $display("FAIL stats_after_reset: got %0d/%0d/%0d, required 0/0/0",
                             bubble_cnt, redirect_cnt, memwait_cnt);
                else n_pass++;
            end
`endif
            k++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(s_idle());
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_dmem_squash();
        test_branch_combo();
        test_back_to_back();
        test_reset_mid_squash();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
